doa_angle_tracker: RTL and testbench



---
 rtl/doa_angle_tracker.sv | 207 ++++++++++++++++++++
 tb/tb_doa_angle_tracker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/doa_angle_tracker.sv
// Azimuth tracker fed by the DOA search stage: range/jump gating, circular
// history with a rounded moving average, lock status and stall timeout.
module doa_angle_tracker #(
  parameter int ANGLE_WIDTH    = 10,
  parameter int ANGLE_MAX      = 90,
  parameter int HIST_DEPTH     = 8,
  parameter int MAX_JUMP       = 10,
  parameter int LOCK_COUNT     = 3,
  parameter int MISS_LIMIT     = 3,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                          iclk,
  input  logic                          irst,
  input  logic [ANGLE_WIDTH-1:0]        iazimuth_angle,
  input  logic                          idoa_search_done,
  input  logic                          iclear,
  output logic [ANGLE_WIDTH-1:0]        osmooth_angle,
  output logic                          oangle_valid,
  output logic                          olocked,
  output logic                          oreject,
  output logic                          otimeout,
  output logic [$clog2(HIST_DEPTH):0]   ohist_count
);

  localparam int PW  = $clog2(HIST_DEPTH);
  localparam int CW  = PW + 1;
  localparam int SW  = ANGLE_WIDTH + PW;
  localparam int SW1 = SW + 1;
  localparam int DW  = ANGLE_WIDTH + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int STW = $clog2(LOCK_COUNT + 1);
  localparam int MW  = $clog2(MISS_LIMIT + 1);

  localparam logic [ANGLE_WIDTH-1:0] AMAX  = ANGLE_WIDTH'(ANGLE_MAX);
  localparam logic [DW-1:0]          JMAX  = DW'(MAX_JUMP);
  localparam logic [CW-1:0]          FULLC = CW'(HIST_DEPTH);
  localparam logic [SW1-1:0]         HALF  = SW1'(HIST_DEPTH / 2);
  localparam logic [TW-1:0]          TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [STW-1:0]         LC    = STW'(LOCK_COUNT);
  localparam logic [MW-1:0]          ML    = MW'(MISS_LIMIT);

  typedef enum logic [1:0] {S_EMPTY, S_ACQUIRE, S_LOCKED} state_t;

  state_t                 r_state, w_state_next;
  logic [ANGLE_WIDTH-1:0] r_hist [HIST_DEPTH];
  logic [SW-1:0]          r_sum;
  logic [CW-1:0]          r_count;
  logic [PW-1:0]          r_wr_ptr;
  logic [STW-1:0]         r_streak, w_streak_next;
  logic [MW-1:0]          r_miss, w_miss_next;
  logic [TW-1:0]          r_tmo_cnt, w_tmo_next;
  logic [ANGLE_WIDTH-1:0] r_last;
  logic [ANGLE_WIDTH-1:0] r_ref;
  logic                   r_valid_pend, r_reject_pend, r_tmo_pend;

  logic                   w_reseed, w_accept, w_reject, w_flush, w_tmo_fire;
  logic                   w_in_range, w_in_gate, w_full;
  logic [ANGLE_WIDTH-1:0] w_ref, w_old, w_smooth_acc;
  logic [DW-1:0]          w_diff;
  logic [SW-1:0]          w_sum_acc;
  logic [SW1-1:0]         w_round;
  logic [CW-1:0]          w_count_acc;

  // In LOCKED the gate is centred on the published average, otherwise on the last sample.
  assign w_in_range = (iazimuth_angle <= AMAX);
  assign w_ref      = (r_state == S_LOCKED) ? r_ref : r_last;
  assign w_diff     = (iazimuth_angle >= w_ref) ? ({1'b0, iazimuth_angle} - {1'b0, w_ref})
                                                : ({1'b0, w_ref} - {1'b0, iazimuth_angle});
  assign w_in_gate  = (w_diff <= JMAX);

  assign w_full       = (r_count == FULLC);
  assign w_old        = w_full ? r_hist[r_wr_ptr] : '0;
  assign w_sum_acc    = r_sum + SW'(iazimuth_angle) - SW'(w_old);
  assign w_count_acc  = w_full ? r_count : r_count + 1'b1;
  assign w_round      = {1'b0, w_sum_acc} + HALF;
  assign w_smooth_acc = (w_count_acc == FULLC) ? ANGLE_WIDTH'(w_round >> PW) : iazimuth_angle;

  always_comb begin
    w_state_next  = r_state;
    w_streak_next = r_streak;
    w_miss_next   = r_miss;
    w_tmo_next    = r_tmo_cnt;
    w_reseed      = 1'b0;
    w_accept      = 1'b0;
    w_reject      = 1'b0;
    w_flush       = 1'b0;
    w_tmo_fire    = 1'b0;
    if (iclear) begin
      w_flush = 1'b1;
    end else if (idoa_search_done) begin
      w_tmo_next = '0;
      if (!w_in_range) begin
        w_reject = 1'b1;
      end else begin
        case (r_state)
          S_EMPTY: w_reseed = 1'b1;
          S_ACQUIRE: begin
            if (w_in_gate) begin
              w_accept      = 1'b1;
              w_streak_next = r_streak + 1'b1;
              if (w_streak_next >= LC) w_state_next = S_LOCKED;
            end else begin
              w_reseed = 1'b1;
            end
          end
          S_LOCKED: begin
            if (w_in_gate) begin
              w_accept    = 1'b1;
              w_miss_next = '0;
            end else if ((r_miss + 1'b1) >= ML) begin
              w_reseed = 1'b1;
            end else begin
              w_reject    = 1'b1;
              w_miss_next = r_miss + 1'b1;
            end
          end
          default: w_flush = 1'b1;
        endcase
      end
    end else if (r_state != S_EMPTY) begin
      if (r_tmo_cnt >= TLAST) begin
        w_flush    = 1'b1;
        w_tmo_fire = 1'b1;
      end else begin
        w_tmo_next = r_tmo_cnt + 1'b1;
      end
    end
    if (w_reseed) begin
      w_state_next  = S_ACQUIRE;
      w_streak_next = STW'(1);
      w_miss_next   = '0;
    end
    if (w_flush) begin
      w_state_next  = S_EMPTY;
      w_streak_next = '0;
      w_miss_next   = '0;
      w_tmo_next    = '0;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
    end else if (w_flush || w_reseed) begin
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
      if (w_reseed) r_hist[0] <= iazimuth_angle;
    end else if (w_accept) begin
      r_hist[r_wr_ptr] <= iazimuth_angle;
    end
  end

  // Tracker state moves on the capture edge; published outputs follow one edge later.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_state       <= S_EMPTY;
      r_streak      <= '0;
      r_miss        <= '0;
      r_tmo_cnt     <= '0;
      r_sum         <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_last        <= '0;
      r_ref         <= '0;
      r_valid_pend  <= 1'b0;
      r_reject_pend <= 1'b0;
      r_tmo_pend    <= 1'b0;
      osmooth_angle <= '0;
      oangle_valid  <= 1'b0;
      olocked       <= 1'b0;
      oreject       <= 1'b0;
      otimeout      <= 1'b0;
      ohist_count   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_streak      <= w_streak_next;
      r_miss        <= w_miss_next;
      r_tmo_cnt     <= w_tmo_next;
      r_valid_pend  <= w_accept | w_reseed;
      r_reject_pend <= w_reject;
      r_tmo_pend    <= w_tmo_fire;
      if (w_flush) begin
        r_sum    <= '0;
        r_count  <= '0;
        r_wr_ptr <= '0;
      end else if (w_reseed) begin
        r_sum    <= SW'(iazimuth_angle);
        r_count  <= CW'(1);
        r_wr_ptr <= PW'(1);
        r_last   <= iazimuth_angle;
        r_ref    <= iazimuth_angle;
      end else if (w_accept) begin
        r_sum    <= w_sum_acc;
        r_count  <= w_count_acc;
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_last   <= iazimuth_angle;
        r_ref    <= w_smooth_acc;
      end
      oangle_valid <= r_valid_pend;
      oreject      <= r_reject_pend;
      otimeout     <= r_tmo_pend;
      olocked      <= (r_state == S_LOCKED);
      ohist_count  <= r_count;
      if (r_valid_pend) osmooth_angle <= r_ref;
    end
  end

endmodule

// File: tb/tb_doa_angle_tracker.sv
// Directed bench for doa_angle_tracker: lock, averaging, gating, range, timeout, clear, reset.
module tb_doa_angle_tracker;

  logic       clk;
  logic       rst;
  logic [9:0] angle;
  logic       done;
  logic       clr;
  logic [9:0] smooth;
  logic       valid;
  logic       locked;
  logic       rej;
  logic       tmo;
  logic [3:0] cnt;

  int total = 0;
  int bad   = 0;

  doa_angle_tracker #(.TIMEOUT_CYCLES(100)) dut (
    .iclk(clk), .irst(rst), .iazimuth_angle(angle), .idoa_search_done(done),
    .iclear(clr), .osmooth_angle(smooth), .oangle_valid(valid), .olocked(locked),
    .oreject(rej), .otimeout(tmo), .ohist_count(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One pulse; returns at the negedge where its outputs are visible.
  task automatic send(input logic [9:0] a);
    @(negedge clk);
    angle = a;
    done  = 1'b1;
    @(negedge clk);
    done  = 1'b0;
    @(negedge clk);
    $display("txn angle=%0d valid=%0b rej=%0b smooth=%0d lock=%0b cnt=%0d", a, valid, rej, smooth, locked, cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    send(30); send(31); send(32);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL reset_prelock got=%0b want=1", locked); end
    #2 rst = 1'b1;
    #1;
    total++; if (smooth !== 10'd0) begin bad++; $display("FAIL reset_smooth got=%0d want=0", smooth); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0b want=0", locked); end
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cnt); end
    total++; if ({valid, rej, tmo} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {valid, rej, tmo}); end
    @(negedge clk);
    rst = 1'b0;
    send(70);
    total++; if ({valid, locked, cnt, smooth} !== {1'b1, 1'b0, 4'd1, 10'd70}) begin
      bad++; $display("FAIL reset_reseed got v=%0b l=%0b c=%0d s=%0d want v=1 l=0 c=1 s=70", valid, locked, cnt, smooth); end
  endtask

  task automatic test_lock_fill();
    logic [9:0] exp_tail [3];
    exp_tail[0] = 10'd38; exp_tail[1] = 10'd39; exp_tail[2] = 10'd40;
    do_reset();
    send(30); send(31);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%0b want=0", locked); end
    send(32);
    total++; if ({locked, smooth, cnt} !== {1'b1, 10'd32, 4'd3}) begin
      bad++; $display("FAIL lock_enter got l=%0b s=%0d c=%0d want l=1 s=32 c=3", locked, smooth, cnt); end
    for (int i = 0; i < 4; i++) send(40);
    total++; if ({smooth, cnt} !== {10'd40, 4'd7}) begin
      bad++; $display("FAIL fill_partial got s=%0d c=%0d want s=40 c=7", smooth, cnt); end
    send(40);
    total++; if ({smooth, cnt, valid} !== {10'd37, 4'd8, 1'b1}) begin
      bad++; $display("FAIL fill_avg got s=%0d c=%0d v=%0b want s=37 c=8 v=1", smooth, cnt, valid); end
    for (int i = 0; i < 3; i++) begin
      send(40);
      total++; if (smooth !== exp_tail[i]) begin bad++; $display("FAIL wrap_avg%0d got=%0d want=%0d", i, smooth, exp_tail[i]); end
    end
  endtask

  task automatic test_rounding();
    do_reset();
    for (int i = 0; i < 4; i++) send(40);
    for (int i = 0; i < 4; i++) send(41);
    total++; if ({smooth, cnt} !== {10'd41, 4'd8}) begin
      bad++; $display("FAIL round_half got s=%0d c=%0d want s=41 c=8", smooth, cnt); end
    do_reset();
    for (int i = 0; i < 7; i++) send(40);
    send(43);
    total++; if ({smooth, cnt} !== {10'd40, 4'd8}) begin
      bad++; $display("FAIL round_down got s=%0d c=%0d want s=40 c=8", smooth, cnt); end
  endtask

  task automatic test_outlier();
    for (int i = 0; i < 2; i++) begin
      send(60);
      total++; if ({rej, valid, locked, smooth} !== {1'b1, 1'b0, 1'b1, 10'd40}) begin
        bad++; $display("FAIL miss%0d got r=%0b v=%0b l=%0b s=%0d want r=1 v=0 l=1 s=40", i, rej, valid, locked, smooth); end
    end
    send(60);
    total++; if ({rej, valid, locked, smooth, cnt} !== {1'b0, 1'b1, 1'b0, 10'd60, 4'd1}) begin
      bad++; $display("FAIL miss_reseed got r=%0b v=%0b l=%0b s=%0d c=%0d want r=0 v=1 l=0 s=60 c=1", rej, valid, locked, smooth, cnt); end
  endtask

  task automatic test_range();
    send(95);
    total++; if ({rej, valid, locked, cnt, smooth} !== {1'b1, 1'b0, 1'b0, 4'd1, 10'd60}) begin
      bad++; $display("FAIL range_rej got r=%0b v=%0b l=%0b c=%0d s=%0d want r=1 v=0 l=0 c=1 s=60", rej, valid, locked, cnt, smooth); end
    send(90);
    total++; if ({rej, valid, cnt, smooth} !== {1'b0, 1'b1, 4'd1, 10'd90}) begin
      bad++; $display("FAIL range_jump got r=%0b v=%0b c=%0d s=%0d want r=0 v=1 c=1 s=90", rej, valid, cnt, smooth); end
    send(85);
    total++; if ({valid, cnt, smooth} !== {1'b1, 4'd2, 10'd85}) begin
      bad++; $display("FAIL acq_accept got v=%0b c=%0d s=%0d want v=1 c=2 s=85", valid, cnt, smooth); end
    send(90);
    total++; if ({valid, cnt, smooth, locked} !== {1'b1, 4'd3, 10'd90, 1'b1}) begin
      bad++; $display("FAIL max_accept got v=%0b c=%0d s=%0d l=%0b want v=1 c=3 s=90 l=1", valid, cnt, smooth, locked); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk); angle = 10'd30; done = 1'b1;
    @(negedge clk); angle = 10'd31;
    @(negedge clk); angle = 10'd32;
    @(negedge clk); done = 1'b0;
    total++; if ({valid, smooth, cnt} !== {1'b1, 10'd31, 4'd2}) begin
      bad++; $display("FAIL b2b_second got v=%0b s=%0d c=%0d want v=1 s=31 c=2", valid, smooth, cnt); end
    @(negedge clk);
    total++; if ({valid, smooth, cnt, locked} !== {1'b1, 10'd32, 4'd3, 1'b1}) begin
      bad++; $display("FAIL b2b_third got v=%0b s=%0d c=%0d l=%0b want v=1 s=32 c=3 l=1", valid, smooth, cnt, locked); end
  endtask

  task automatic test_timeout();
    int k;
    do_reset();
    send(30); send(31); send(32);
    k = 1;
    while (tmo !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    total++; if (k !== 101) begin bad++; $display("FAIL tmo_cycle got=%0d want=101", k); end
    total++; if ({tmo, locked, cnt, smooth, valid} !== {1'b1, 1'b0, 4'd0, 10'd32, 1'b0}) begin
      bad++; $display("FAIL tmo_flush got t=%0b l=%0b c=%0d s=%0d v=%0b want t=1 l=0 c=0 s=32 v=0", tmo, locked, cnt, smooth, valid); end
    @(negedge clk);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL tmo_pulse got=%0b want=0", tmo); end
  endtask

  task automatic test_clear();
    send(20);
    total++; if ({valid, cnt} !== {1'b1, 4'd1}) begin bad++; $display("FAIL clr_pre got v=%0b c=%0d want v=1 c=1", valid, cnt); end
    @(negedge clk); angle = 10'd50; done = 1'b1; clr = 1'b1;
    @(negedge clk); done = 1'b0; clr = 1'b0;
    @(negedge clk);
    total++; if ({valid, rej, tmo, cnt, smooth} !== {3'b000, 4'd0, 10'd20}) begin
      bad++; $display("FAIL clr_drop got v=%0b r=%0b t=%0b c=%0d s=%0d want v=0 r=0 t=0 c=0 s=20", valid, rej, tmo, cnt, smooth); end
    send(25);
    total++; if ({valid, cnt, smooth} !== {1'b1, 4'd1, 10'd25}) begin
      bad++; $display("FAIL clr_empty got v=%0b c=%0d s=%0d want v=1 c=1 s=25", valid, cnt, smooth); end
  endtask

  initial begin
    rst = 1'b1; angle = '0; done = 1'b0; clr = 1'b0;
    test_reset();
    test_lock_fill();
    test_rounding();
    test_outlier();
    test_range();
    test_back_to_back();
    test_timeout();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
